// File: rtl/adc_spi_responder.sv
// SPI responder standing in for the board's serial ADC. It serializes held samples
// MSB-first on SDO inside a CS window, clocked by the initiator's SCLK (idles high).
module adc_spi_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  CS,
  input  logic                  SCLK,
  output logic                  SDO,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  FRAME_ABORT,
  output logic                  UNDERRUN
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, cs_fall, cs_rise, sclk_fall, sclk_rise;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, hold_q, hold_d, last_q, last_d;
  logic                   hold_full_q, hold_full_d, sampled_q, sampled_d;
  logic                   sdo_q, sdo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d, abort_q, abort_d, underrun_q, underrun_d;
  logic                   last_bit;

  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  // CS resets low so a CS already low at reset release is never seen as a fall.
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign sclk_fall   = sclk_prev_q & ~sclk_s;
  assign sclk_rise   = ~sclk_prev_q & sclk_s;
  assign last_bit    = (cnt_q == LAST_CNT);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cs_sync_q   <= '0;
      sclk_sync_q <= '1;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b1;
      shift_q     <= '0;
      hold_q      <= '0;
      last_q      <= '0;
      hold_full_q <= 1'b0;
      sampled_q   <= 1'b0;
      sdo_q       <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      hold_full_q <= hold_full_d;
      sampled_q   <= sampled_d;
      sdo_q       <= sdo_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise) state_d = IDLE;
        else if (last_bit && (sclk_rise || (sclk_fall && sampled_q))) state_d = DRAIN;
      end
      DRAIN:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    hold_d      = hold_q;
    last_d      = last_q;
    hold_full_d = hold_full_q;
    sampled_d   = sampled_q;
    sdo_d       = sdo_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            last_d      = hold_q;
            hold_full_d = 1'b0;
            sdo_d       = hold_q[DATA_WIDTH-1];
          end else begin
            shift_d    = last_q;
            underrun_d = 1'b1;
            sdo_d      = last_q[DATA_WIDTH-1];
          end
          cnt_d     = CNT_W'(1);
          sampled_d = 1'b0;
        end
      end
      SHIFT: begin
        // The MSB is already on SDO from the CS fall, so a fall only advances
        // once the initiator has sampled the current bit on a rise.
        if (cs_rise) begin
          abort_d = 1'b1;
          sdo_d   = 1'b0;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          sampled_d = 1'b1;
          if (last_bit) sdo_d = 1'b0;
        end else if (sclk_fall && sampled_q) begin
          if (last_bit) begin
            sdo_d = 1'b0;
          end else begin
            shift_d   = shift_q << 1;
            sdo_d     = shift_q[DATA_WIDTH-2];
            cnt_d     = cnt_q + CNT_W'(1);
            sampled_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        sdo_d = 1'b0;
        if (cs_rise) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: sdo_d = 1'b0;
    endcase
    // An empty holding register accepts a word even on the frame-start cycle.
    if (LOAD_VALID && !hold_full_q) begin
      hold_d      = LOAD_DATA;
      hold_full_d = 1'b1;
    end
  end

  assign SDO         = sdo_q;
  assign LOAD_READY  = ~hold_full_q;
  assign BUSY        = (state_q != IDLE);
  assign FRAME_DONE  = done_q;
  assign FRAME_ABORT = abort_q;
  assign UNDERRUN    = underrun_q;

endmodule
